// File: rtl/arb_pkg.sv
`default_nettype none
// =============================================================================
// arb_pkg : shared constants, state encoding and helpers for rr_arbiter16
// Revision: 1.0
// =============================================================================
package arb_pkg;

    localparam int ARB_N      = 16;
    localparam int ARB_IDX_W  = 4;
    localparam int ARB_HOLD_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Next index in rotation order; the 4-bit add wraps 15 back to 0.
    function automatic logic [ARB_IDX_W-1:0] arb_next_idx(input logic [ARB_IDX_W-1:0] idx);
        return idx + ARB_IDX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pri_encoder16.sv
`default_nettype none
// =============================================================================
// pri_encoder16 : 16-to-4 priority encoder, lowest set bit wins
// Revision: 1.0
// =============================================================================
module pri_encoder16
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req_i,
    output logic [ARB_IDX_W-1:0] idx_o,
    output logic                 valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = ARB_IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter16.sv
`default_nettype none
// =============================================================================
// rr_arbiter16 : 16-way round-robin arbiter, hold-until-release, registered grant
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
// Revision: 1.0
// =============================================================================
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter16: MAX_HOLD must be in 1..255");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             valid_q, valid_d;

    logic             w_force;
    logic             w_release;
    logic             w_new_grant;
    logic [IDX_W-1:0] w_ptr;
    logic [N-1:0]     w_req_m;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_valid;
    logic [IDX_W-1:0] w_win;

    // On release the owner is masked out, which also covers a forced eviction.
    always_comb begin
        w_release = (state_q == ST_BUSY) && (!req_i[idx_q] || w_force);
        w_ptr     = (state_q == ST_BUSY) ? arb_next_idx(idx_q) : ptr_q;
        w_req_m   = req_i;
        if (state_q == ST_BUSY) begin
            w_req_m[idx_q] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            w_rot[i] = w_req_m[IDX_W'(i) + w_ptr];
        end
    end

    pri_encoder16 u_enc (
        .req_i   (w_rot),
        .idx_o   (w_enc_idx),
        .valid_o (w_enc_valid)
    );

    assign w_win       = w_enc_idx + w_ptr;
    assign w_new_grant = w_enc_valid && ((state_q == ST_IDLE) || w_release);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        if (w_new_grant) begin
            state_d = ST_BUSY;
            gnt_d   = N'(1) << w_win;
            idx_d   = w_win;
            valid_d = 1'b1;
        end else if (w_release) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end
        if (w_release) begin
            ptr_d = w_ptr;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [ARB_HOLD_W-1:0] c_HOLD_LAST = ARB_HOLD_W'(MAX_HOLD - 1);

    logic [ARB_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  timeout_q, timeout_d;

    assign w_force     = (state_q == ST_BUSY) && req_i[idx_q] && (hold_cnt_q == c_HOLD_LAST);
    assign hold_cnt_d  = w_new_grant ? '0 :
                         (state_q == ST_BUSY) ? hold_cnt_q + ARB_HOLD_W'(1) : hold_cnt_q;
    assign timeout_d   = w_release && w_force;
    assign timeout_o   = timeout_q;
`else
    assign w_force     = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter16.sv
`default_nettype none
// =============================================================================
// tb_rr_arbiter16 : directed + randomized bench with a behavioural reference model
// Revision: 1.0
// =============================================================================
module tb_rr_arbiter16;

    localparam int c_MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner index (-1 = none), priority pointer, hold length.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    rr_arbiter16 #(.MAX_HOLD(c_MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input int p);
        for (int j = 0; j < 16; j++) begin
            if (r[(p + j) % 16]) return (p + j) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [15:0] r);
        logic [15:0] masked;
        bit          forced;
        m_to = 1'b0;
        if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
            m_hold  = 0;
        end else begin
            forced = c_TO_EN && r[m_owner] && (m_hold == c_MAX_HOLD - 1);
            if (!r[m_owner] || forced) begin
                m_ptr          = (m_owner + 1) % 16;
                masked         = r;
                masked[m_owner] = 1'b0;
                m_owner        = pick(masked, m_ptr);
                m_hold         = 0;
                m_to           = forced;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] eg;
        eg = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        chk({tag, ".gnt"},   32'(gnt),       32'(eg));
        chk({tag, ".idx"},   32'(gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        chk({tag, ".to"},    32'(timeout),   32'(m_to));
    endtask

    // Drive req away from the edge, advance one edge, then compare.
    task automatic step(input logic [15:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
    endtask

    // Pulse reset between edges and check that outputs clear without a clock.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".gnt"},   32'(gnt),       32'd0);
        chk({tag, ".idx"},   32'(gnt_idx),   32'd0);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, ".to"},    32'(timeout),   32'd0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        int          cur;
        model_reset();
        rst_n = 1'b0;
        req   = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        // Single requester grant and release; ptr moves to 1.
        step(16'h0001, "s1_grant");
        chk("s1_gnt", 32'(gnt), 32'h0001);
        step(16'h0000, "s1_release");
        chk("s1_rel_valid", 32'(gnt_valid), 32'd0);
        step(16'h0003, "s1_ptr1");
        chk("s1_ptr1_idx", 32'(gnt_idx), 32'd1);
        step(16'h0000, "s1_idle");

        // Owner 0 hands over to 15 without a bubble; ptr then wraps to 0.
        do_reset("s2_rst");
        step(16'h8001, "s2_a");
        step(16'h8001, "s2_b");
        step(16'h8001, "s2_c");
        chk("s2_own0", 32'(gnt_idx), 32'd0);
        step(16'h8000, "s2_handover");
        chk("s2_idx15", 32'(gnt), 32'h8000);
        step(16'h0000, "s2_drop");
        step(16'h8001, "s2_wrap");
        chk("s2_wrap_idx", 32'(gnt_idx), 32'd0);

        // All requesting, each owner drops for one cycle: strict rotation.
        do_reset("s3_rst");
        step(16'hFFFF, "s3_first");
        chk("s3_rot0", 32'(gnt_idx), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            cur = int'(gnt_idx);
            r = 16'hFFFF;
            r[cur] = 1'b0;
            step(r, "s3_rot");
            chk("s3_rot_idx", 32'(gnt_idx), 32'(i % 16));
        end

        // Reset while idx 5 owns the resource, then regrant after reset.
        do_reset("s4_rst0");
        step(16'h0020, "s4_a");
        step(16'h0020, "s4_b");
        chk("s4_own5", 32'(gnt_idx), 32'd5);
        do_reset("s4_midrst");
        step(16'h0020, "s4_regrant");
        chk("s4_regrant_idx", 32'(gnt_idx), 32'd5);

        // Owner 3 drops as req[2] rises; ptr=4 makes 9 the winner.
        do_reset("s5_rst");
        step(16'h0208, "s5_a");
        chk("s5_own3", 32'(gnt_idx), 32'd3);
        step(16'h0208, "s5_b");
        step(16'h0204, "s5_swap");
        chk("s5_win9", 32'(gnt_idx), 32'd9);

        // Constant requests from 0 and 4: timeout rotation or indefinite hold.
        do_reset("s6_rst");
        step(16'h0011, "s6_first");
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 8; i++) step(16'h0011, "s6_hold0");
        step(16'h0011, "s6_evict0");
        chk("s6_idx4", 32'(gnt_idx), 32'd4);
        chk("s6_to", 32'(timeout), 32'd1);
        for (int i = 1; i < 8; i++) step(16'h0011, "s6_hold4");
        step(16'h0011, "s6_evict4");
        chk("s6_back0", 32'(gnt_idx), 32'd0);
        chk("s6_to2", 32'(timeout), 32'd1);
`else
        for (int i = 0; i < 110; i++) step(16'h0011, "s6_hold");
        chk("s6_still0", 32'(gnt_idx), 32'd0);
        chk("s6_no_to", 32'(timeout), 32'd0);
`endif

        // Randomized traffic; the current owner usually keeps requesting.
        do_reset("rnd_rst");
        for (int i = 0; i < 600; i++) begin
            r = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) r = 16'h0;
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            step(r, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
